// File: rtl/ehgu_fifo_wctl.sv
// Write-side credit controller for the ehgu FIFO: gates an upstream valid/ready
// stream onto the FIFO write port by free-entry credits and caps burst length.
module ehgu_fifo_wctl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned CWIDTH   = $clog2(DEPTH + 1)
) (
  input  logic              clk0,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  output logic              din_valid,
  output logic [WIDTH-1:0]  din,
  input  logic              crd_ret,
  output logic [CWIDTH-1:0] credits,
  output logic              full,
  output logic              empty,
  output logic              crd_err
);

  localparam int unsigned BW = $clog2(MAX_BURST + 2);
  localparam logic [CWIDTH-1:0] DEPTH_C = CWIDTH'(DEPTH);
  localparam logic [BW-1:0]     MAXB_C  = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      bcnt_q, bcnt_d, bcnt_inc;
  logic [CWIDTH-1:0]  credits_q, credits_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               crd_err_q, crd_err_d;
  logic               din_valid_q, din_valid_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic               fire;

  always_comb begin
    s_ready = !rst && en && (credits_q != '0) && (state_q != GAP);
    fire    = s_valid && s_ready;
  end

  always_comb begin
    credits_d   = credits_q;
    crd_err_d   = crd_err_q;
    din_valid_d = fire;
    din_d       = fire ? s_data : din_q;
    // a write and a returned credit in the same cycle cancel out
    if (fire && !crd_ret) begin
      credits_d = credits_q - 1'b1;
    end else if (!fire && crd_ret) begin
      if (credits_q == DEPTH_C) crd_err_d = 1'b1;
      else                      credits_d = credits_q + 1'b1;
    end
    full_d  = (credits_d == '0);
    empty_d = (credits_d == DEPTH_C);
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bcnt_inc = bcnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (MAX_BURST == 1) begin
            state_d = GAP;
            bcnt_d  = '0;
          end else begin
            state_d = BURST;
            bcnt_d  = (MAX_BURST == 0) ? '0 : BW'(1);
          end
        end
      end
      BURST: begin
        if (fire) begin
          if (MAX_BURST != 0) begin
            if (bcnt_inc == MAXB_C) begin
              state_d = GAP;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_inc;
            end
          end
        end else begin
          state_d = IDLE;
          bcnt_d  = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      credits_q   <= DEPTH_C;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      crd_err_q   <= 1'b0;
      din_valid_q <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      credits_q   <= credits_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      crd_err_q   <= crd_err_d;
      din_valid_q <= din_valid_d;
      din_q       <= din_d;
    end
  end

  assign din_valid = din_valid_q;
  assign din       = din_q;
  assign credits   = credits_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign crd_err   = crd_err_q;

endmodule

// File: tb/tb_ehgu_fifo_wctl.sv
// Directed bench for ehgu_fifo_wctl: instance A (DEPTH=4, no burst cap) and
// instance B (DEPTH=8, MAX_BURST=3); written data checked via per-instance queues.
module tb_ehgu_fifo_wctl;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic rst = 1'b1;

  logic       a_en, a_s_valid, a_s_ready, a_din_valid, a_crd_ret, a_full, a_empty, a_crd_err;
  logic [7:0] a_s_data, a_din;
  logic [2:0] a_credits;

  logic       b_en, b_s_valid, b_s_ready, b_din_valid, b_crd_ret, b_full, b_empty, b_crd_err;
  logic [7:0] b_s_data, b_din;
  logic [3:0] b_credits;

  int checks = 0;
  int errors = 0;
  int b_wr   = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  ehgu_fifo_wctl #(.WIDTH(8), .DEPTH(4), .MAX_BURST(0)) u_a (
    .clk0(clk0), .rst(rst), .en(a_en), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .s_data(a_s_data), .din_valid(a_din_valid), .din(a_din), .crd_ret(a_crd_ret),
    .credits(a_credits), .full(a_full), .empty(a_empty), .crd_err(a_crd_err)
  );

  ehgu_fifo_wctl #(.WIDTH(8), .DEPTH(8), .MAX_BURST(3)) u_b (
    .clk0(clk0), .rst(rst), .en(b_en), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_data(b_s_data), .din_valid(b_din_valid), .din(b_din), .crd_ret(b_crd_ret),
    .credits(b_credits), .full(b_full), .empty(b_empty), .crd_err(b_crd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  // Scoreboard side: every write strobe must match the oldest queued datum.
  always @(negedge clk0) begin
    if (a_din_valid === 1'b1) begin
      chk("a_wr_pending", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) chk("a_din", 32'(a_din), 32'(qa.pop_front()));
    end
    if (b_din_valid === 1'b1) begin
      b_wr++;
      chk("b_wr_pending", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) chk("b_din", 32'(b_din), 32'(qb.pop_front()));
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] bd;
    logic       exp_rdy;
    a_en = 1'b1; a_s_valid = 1'b0; a_s_data = '0; a_crd_ret = 1'b0;
    b_en = 1'b1; b_s_valid = 1'b0; b_s_data = '0; b_crd_ret = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_a_credits", a_credits, 4);
    chk("rst_a_empty", a_empty, 1);
    chk("rst_a_full", a_full, 0);
    chk("rst_a_din_valid", a_din_valid, 0);
    chk("rst_a_s_ready", a_s_ready, 0);
    chk("rst_a_crd_err", a_crd_err, 0);
    chk("rst_a_din", a_din, 0);
    chk("rst_b_credits", b_credits, 8);
    chk("rst_b_s_ready", b_s_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_s_ready", a_s_ready, 1);
    chk("post_rst_b_s_ready", b_s_ready, 1);

    // Burst cap on B: 3 on, 1 off
    b_s_valid = 1'b1;
    bd = 8'd1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = (k % 4) != 3;
      b_s_data = bd;
      chk("b_cap_s_ready", b_s_ready, exp_rdy);
      if (exp_rdy) qb.push_back(bd);
      tick();
      chk("b_cap_din_valid", b_din_valid, exp_rdy);
      if (exp_rdy) bd = bd + 8'd1;
    end
    b_s_valid = 1'b0;
    chk("b_cap_credits", b_credits, 2);
    tick();
    chk("b_cap_writes", b_wr, 6);

    // Fill A
    a_s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_s_data = 8'(i);
      chk("fill_s_ready", a_s_ready, 1);
      qa.push_back(8'(i));
      tick();
      chk("fill_credits", a_credits, 32'(4 - i));
      chk("fill_din_valid", a_din_valid, 1);
    end
    a_s_data = 8'd5;
    chk("full_flag", a_full, 1);
    chk("full_s_ready", a_s_ready, 0);
    chk("full_empty", a_empty, 0);
    tick(); tick();
    chk("full_hold_credits", a_credits, 0);
    chk("full_hold_din_valid", a_din_valid, 0);

    // Refill with one credit
    a_crd_ret = 1'b1;
    tick();
    a_crd_ret = 1'b0;
    chk("refill_credits", a_credits, 1);
    chk("refill_s_ready", a_s_ready, 1);
    chk("refill_full", a_full, 0);
    qa.push_back(8'd5);
    tick();
    a_s_valid = 1'b0;
    chk("refill_credits_after", a_credits, 0);
    chk("refill_full_after", a_full, 1);
    chk("refill_din_valid", a_din_valid, 1);

    // Fire and credit return together at credits=2
    a_crd_ret = 1'b1;
    tick(); tick();
    a_crd_ret = 1'b0;
    chk("two_returns_credits", a_credits, 2);
    a_s_valid = 1'b1; a_s_data = 8'd6; a_crd_ret = 1'b1;
    qa.push_back(8'd6);
    tick();
    a_s_valid = 1'b0; a_crd_ret = 1'b0;
    chk("simul_credits", a_credits, 2);
    chk("simul_din_valid", a_din_valid, 1);

    // Over-return sets sticky error
    a_crd_ret = 1'b1;
    tick(); tick();
    chk("top_credits", a_credits, 4);
    chk("top_crd_err", a_crd_err, 0);
    tick();
    a_crd_ret = 1'b0;
    chk("over_credits", a_credits, 4);
    chk("over_crd_err", a_crd_err, 1);
    chk("over_empty", a_empty, 1);
    tick();
    chk("sticky_crd_err", a_crd_err, 1);

    // en toggle mid-burst
    a_s_valid = 1'b1; a_s_data = 8'd7;
    qa.push_back(8'd7);
    tick();
    chk("en_fire_credits", a_credits, 3);
    a_en = 1'b0; a_s_data = 8'd8; a_crd_ret = 1'b1;
    #1;
    chk("en0_s_ready", a_s_ready, 0);
    tick();
    a_crd_ret = 1'b0;
    chk("en0_din_valid", a_din_valid, 0);
    chk("en0_credits", a_credits, 4);
    tick();
    chk("en0_din_valid2", a_din_valid, 0);
    a_en = 1'b1;
    #1;
    chk("en1_s_ready", a_s_ready, 1);
    qa.push_back(8'd8);
    tick();
    a_s_valid = 1'b0;
    chk("en1_din_valid", a_din_valid, 1);
    chk("en1_credits", a_credits, 3);

    // Reset mid-burst
    a_s_valid = 1'b1; a_s_data = 8'd9;
    qa.push_back(8'd9);
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_din_valid", a_din_valid, 0);
    chk("rstmid_credits", a_credits, 4);
    chk("rstmid_crd_err", a_crd_err, 0);
    chk("rstmid_empty", a_empty, 1);
    chk("rstmid_s_ready", a_s_ready, 0);
    rst = 1'b0; a_s_valid = 1'b0;
    tick(); tick();
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
